// File: rtl/lz77_pkg.sv
// ---------------------------------------------------------------------------
// lz77_pkg
// Shared constants and types for the LZ77 encoder/decoder pair.
//   STR_LEN      maximum stored characters, terminator included
//   SEARCH_SIZE  search-window depth (code_pos range 0..SEARCH_SIZE-1)
//   LA_SIZE      look-ahead depth (longest match is LA_SIZE-1)
//   POS_W/LEN_W  codeword field widths
//   IDX_W        string index width
//   END_CHAR     string terminator '$'
//   state_t      encoder control states
// ---------------------------------------------------------------------------
package lz77_pkg;

    localparam int STR_LEN     = 2049;
    localparam int SEARCH_SIZE = 9;
    localparam int LA_SIZE     = 8;
    localparam int POS_W       = 4;
    localparam int LEN_W       = 3;
    localparam int IDX_W       = 12;

    localparam logic [7:0] END_CHAR = 8'h24;

    typedef enum logic [1:0] {
        LOAD,
        SEARCH,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/lz77_match_len.sv
// ---------------------------------------------------------------------------
// lz77_match_len
// Combinational match-length unit: counts leading equal characters between a
// search-window slice and the look-ahead slice, clipped to a length cap.
//   win  in   LA_SIZE-1 characters starting at the candidate position
//   la   in   LA_SIZE-1 characters starting at the current position
//   cap  in   longest length allowed for this candidate
//   len  out  match length
// ---------------------------------------------------------------------------
module lz77_match_len
    import lz77_pkg::*;
(
    input  logic [8*(LA_SIZE-1)-1:0] win,
    input  logic [8*(LA_SIZE-1)-1:0] la,
    input  logic [LEN_W-1:0]         cap,
    output logic [LEN_W-1:0]         len
);

    localparam int CMP_N = LA_SIZE - 1;

    logic [CMP_N-1:0] eq;
    logic [LEN_W-1:0] run_len;

    for (genvar gi = 0; gi < CMP_N; gi++) begin : g_cmp
        assign eq[gi] = (win[8*gi +: 8] == la[8*gi +: 8]);
    end

    // Index of the first mismatch; scanning downwards leaves the lowest one.
    always_comb begin
        run_len = LEN_W'(CMP_N);
        for (int k = CMP_N - 1; k >= 0; k--) begin
            if (!eq[k]) begin
                run_len = LEN_W'(k);
            end
        end
    end

    assign len = (run_len < cap) ? run_len : cap;

endmodule

// File: rtl/lz77_encoder.sv
// ---------------------------------------------------------------------------
// lz77_encoder
// Streaming LZ77 encoder. Captures a '$'-terminated string, then evaluates
// one search candidate per cycle and emits one (pos, len, next char) codeword
// every SEARCH_SIZE+1 cycles.
//   clk       in   system clock
//   reset     in   synchronous active-low reset
//   chardata  in   input character, one per cycle while loading
//   encode    out  high while loading/encoding
//   valid     out  one-cycle codeword strobe
//   code_pos  out  match position (0 = most recent character)
//   code_len  out  match length
//   char_nxt  out  literal following the match
//   finish    out  high after the last codeword until reset
// ---------------------------------------------------------------------------
module lz77_encoder
    import lz77_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       chardata,
    output logic             encode,
    output logic             valid,
    output logic [POS_W-1:0] code_pos,
    output logic [LEN_W-1:0] code_len,
    output logic [7:0]       char_nxt,
    output logic             finish
);

    // Padding past STR_LEN keeps every window read in range.
    localparam int BUF_DEPTH = STR_LEN + LA_SIZE;
    localparam int CMP_N     = LA_SIZE - 1;

    logic [7:0] str_buf [0:BUF_DEPTH-1];

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] widx_reg, cur_reg, last_reg;
    logic [POS_W-1:0] pidx_reg, best_p_reg;
    logic [LEN_W-1:0] best_l_reg;
    logic             valid_reg, encode_reg, finish_reg;
    logic [POS_W-1:0] code_pos_reg;
    logic [LEN_W-1:0] code_len_reg;
    logic [7:0]       char_nxt_reg;

    logic             load_end, cand_legal, cand_better, last_cand, emit_last;
    logic [IDX_W-1:0] base_idx, remain, nxt_idx;
    logic [LEN_W-1:0] cap, cand_len, fin_l;
    logic [POS_W-1:0] fin_p;
    logic [8*CMP_N-1:0] win_bytes, la_bytes;

    // A full buffer forces its last character to act as the terminator.
    assign load_end   = (chardata == END_CHAR) || (widx_reg == IDX_W'(STR_LEN - 1));
    assign cand_legal = (cur_reg > IDX_W'(pidx_reg));
    assign base_idx   = cand_legal ? (cur_reg - IDX_W'(pidx_reg) - IDX_W'(1)) : '0;
    assign remain     = last_reg - cur_reg;
    // Capping at last_idx-cur keeps the terminator out of every match.
    assign cap        = !cand_legal ? '0 :
                        (remain >= IDX_W'(CMP_N)) ? LEN_W'(CMP_N) : remain[LEN_W-1:0];

    // Windows are read straight from the string, so a match may run into
    // the look-ahead region.
    for (genvar gi = 0; gi < CMP_N; gi++) begin : g_win
        assign win_bytes[8*gi +: 8] = str_buf[base_idx + IDX_W'(gi)];
        assign la_bytes[8*gi +: 8]  = str_buf[cur_reg + IDX_W'(gi)];
    end

    lz77_match_len u_match_len (
        .win (win_bytes),
        .la  (la_bytes),
        .cap (cap),
        .len (cand_len)
    );

    // Strictly greater: on equal length the earlier (smaller p) candidate stays.
    assign cand_better = (cand_len > best_l_reg);
    assign fin_p       = cand_better ? pidx_reg : best_p_reg;
    assign fin_l       = cand_better ? cand_len : best_l_reg;
    assign last_cand   = (pidx_reg == POS_W'(SEARCH_SIZE - 1));
    assign nxt_idx     = cur_reg + IDX_W'(fin_l);
    assign emit_last   = ((cur_reg + IDX_W'(best_l_reg)) == last_reg);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOAD:    if (load_end) state_next = SEARCH;
            SEARCH:  if (last_cand) state_next = EMIT;
            EMIT:    state_next = emit_last ? DONE : SEARCH;
            default: state_next = DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset && state_reg == LOAD) begin
            str_buf[widx_reg] <= chardata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            widx_reg     <= '0;
            cur_reg      <= '0;
            last_reg     <= '0;
            pidx_reg     <= '0;
            best_p_reg   <= '0;
            best_l_reg   <= '0;
            valid_reg    <= 1'b0;
            encode_reg   <= 1'b0;
            finish_reg   <= 1'b0;
            code_pos_reg <= '0;
            code_len_reg <= '0;
            char_nxt_reg <= '0;
        end else begin
            case (state_reg)
                LOAD: begin
                    encode_reg <= 1'b1;
                    widx_reg   <= widx_reg + IDX_W'(1);
                    if (load_end) begin
                        last_reg   <= widx_reg;
                        cur_reg    <= '0;
                        pidx_reg   <= '0;
                        best_p_reg <= '0;
                        best_l_reg <= '0;
                    end
                end
                SEARCH: begin
                    pidx_reg   <= pidx_reg + POS_W'(1);
                    best_p_reg <= fin_p;
                    best_l_reg <= fin_l;
                    // Outputs are loaded on the final candidate so valid
                    // coincides with the EMIT cycle.
                    if (last_cand) begin
                        valid_reg    <= 1'b1;
                        code_pos_reg <= fin_p;
                        code_len_reg <= fin_l;
                        char_nxt_reg <= str_buf[nxt_idx];
                    end
                end
                EMIT: begin
                    valid_reg  <= 1'b0;
                    cur_reg    <= cur_reg + IDX_W'(best_l_reg) + IDX_W'(1);
                    pidx_reg   <= '0;
                    best_p_reg <= '0;
                    best_l_reg <= '0;
                    if (emit_last) begin
                        encode_reg <= 1'b0;
                        finish_reg <= 1'b1;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign encode   = encode_reg;
    assign valid    = valid_reg;
    assign code_pos = code_pos_reg;
    assign code_len = code_len_reg;
    assign char_nxt = char_nxt_reg;
    assign finish   = finish_reg;

endmodule

// File: tb/tb_lz77_encoder.sv
// ---------------------------------------------------------------------------
// tb_lz77_encoder
// Self-checking bench for lz77_encoder: directed strings with hand-computed
// codewords, randomized strings, a full-buffer string without terminator and
// a reset in the middle of encoding, all checked against a reference encoder.
// ---------------------------------------------------------------------------
module tb_lz77_encoder;
    import lz77_pkg::*;

    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic [LEN_W-1:0] len;
        logic [7:0]       ch;
    } cw_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [7:0]       chardata = 8'h00;
    logic             encode, valid, finish;
    logic [POS_W-1:0] code_pos;
    logic [LEN_W-1:0] code_len;
    logic [7:0]       char_nxt;

    always #5 clk = ~clk;

    lz77_encoder dut (
        .clk      (clk),
        .reset    (reset),
        .chardata (chardata),
        .encode   (encode),
        .valid    (valid),
        .code_pos (code_pos),
        .code_len (code_len),
        .char_nxt (char_nxt),
        .finish   (finish)
    );

    logic [7:0] str_q[$];
    cw_t        exp_q[$];
    int         n_vec = 0, n_err = 0;
    int         cyc = 0, term_cyc = 0, last_cyc = 0, n_seen = 0, exp_n = 0;
    bit         pend_fin = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic cw_t mk(input int p, input int l, input logic [7:0] c);
        cw_t w;
        w.pos = POS_W'(p);
        w.len = LEN_W'(l);
        w.ch  = c;
        return w;
    endfunction

    // Index of the character that ends the stored string.
    function automatic int term_index();
        for (int i = 0; i < str_q.size(); i++) begin
            if (str_q[i] == END_CHAR || i == STR_LEN - 1) return i;
        end
        return str_q.size() - 1;
    endfunction

    // Reference encoder: greedy longest match over the previous SEARCH_SIZE
    // start positions, earliest position on ties.
    task automatic build_model();
        int  last, cur, bl, bp, lim, l;
        bit  done;
        exp_q.delete();
        last = term_index();
        cur  = 0;
        done = 1'b0;
        while (!done) begin
            bl  = 0;
            bp  = 0;
            lim = (last - cur < LA_SIZE - 1) ? last - cur : LA_SIZE - 1;
            for (int p = 0; p < SEARCH_SIZE; p++) begin
                if (cur - 1 - p < 0) continue;
                l = 0;
                while (l < lim && str_q[cur - 1 - p + l] == str_q[cur + l]) l++;
                if (l > bl) begin
                    bl = l;
                    bp = p;
                end
            end
            exp_q.push_back(mk(bp, bl, str_q[cur + bl]));
            if (cur + bl == last) done = 1'b1;
            else cur += bl + 1;
        end
        exp_n = exp_q.size();
    endtask

    task automatic pin(input string name, input int idx, input cw_t want);
        if (idx >= exp_q.size()) check(name, 32'd0, 32'd1);
        else check(name, exp_q[idx], want);
    endtask

    task automatic set_str(input string s);
        str_q.delete();
        for (int i = 0; i < s.len(); i++) str_q.push_back(s[i]);
    endtask

    // Hold reset low for n cycles, check the cleared outputs, then prepare
    // the model for the string now in str_q. Returns at a negedge with
    // reset still low.
    task automatic begin_str(input int n);
        @(negedge clk);
        reset = 1'b0;
        repeat (n) @(negedge clk);
        check("reset_outputs", {encode, valid, code_pos, code_len, char_nxt, finish}, 32'd0);
        n_seen   = 0;
        pend_fin = 1'b0;
        build_model();
    endtask

    task automatic load_str();
        int last;
        last  = term_index();
        reset = 1'b1;
        for (int i = 0; i <= last; i++) begin
            if (i > 0) @(negedge clk);
            chardata = str_q[i];
        end
        term_cyc = cyc;
        @(negedge clk);
        chardata = 8'($urandom);
    endtask

    task automatic finish_str();
        int budget;
        budget = 10 * (exp_n + 2) + 20;
        while (!finish && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!finish) check("finish_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
        check("finish_held", {finish, encode, valid}, 32'b100);
        check("n_codewords", n_seen, exp_n);
    endtask

    // Compare process: every valid strobe against the model, plus timing.
    always @(negedge clk) begin
        cw_t got, want;
        if (pend_fin) begin
            pend_fin = 1'b0;
            check("finish_after_last", {finish, encode}, 32'b10);
        end
        if (valid) begin
            got = {code_pos, code_len, char_nxt};
            if (exp_q.size() == 0) begin
                check("unexpected_valid", got, 32'hFFFF_FFFF);
            end else begin
                want = exp_q.pop_front();
                $display("cw %0d: pos=%0d len=%0d chr=%02h", n_seen, code_pos, code_len, char_nxt);
                check("codeword", got, want);
                if (n_seen == 0) check("first_valid_delay", cyc - term_cyc, 32'd10);
                else check("valid_spacing", cyc - last_cyc, 32'd10);
                check("encode_during_emit", {encode, finish}, 32'b10);
                n_seen++;
                last_cyc = cyc;
                if (exp_q.size() == 0) pend_fin = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int len, alpha;

        set_str("$");
        begin_str(2);
        check("pin_dollar_n", exp_q.size(), 32'd1);
        pin("pin_dollar_0", 0, mk(0, 0, 8'h24));
        load_str();
        finish_str();

        set_str("1111$");
        begin_str(2);
        check("pin_1111_n", exp_q.size(), 32'd2);
        pin("pin_1111_0", 0, mk(0, 0, 8'h31));
        pin("pin_1111_1", 1, mk(0, 3, 8'h24));
        load_str();
        finish_str();

        set_str("ABAB$");
        begin_str(2);
        pin("pin_abab_0", 0, mk(0, 0, 8'h41));
        pin("pin_abab_1", 1, mk(0, 0, 8'h42));
        pin("pin_abab_2", 2, mk(1, 2, 8'h24));
        load_str();
        finish_str();

        set_str("000000000$");
        begin_str(2);
        check("pin_zeros_n", exp_q.size(), 32'd3);
        pin("pin_zeros_0", 0, mk(0, 0, 8'h30));
        pin("pin_zeros_1", 1, mk(0, 7, 8'h30));
        pin("pin_zeros_2", 2, mk(0, 0, 8'h24));
        load_str();
        finish_str();

        // 17-character string: spacing and first-valid delay are checked
        // by the compare process on every strobe.
        str_q.delete();
        for (int i = 0; i < 16; i++) str_q.push_back(8'h30 + 8'($urandom_range(0, 2)));
        str_q.push_back(END_CHAR);
        begin_str(2);
        load_str();
        finish_str();

        // Reset during the second codeword's search, then reload.
        set_str("0123$");
        begin_str(2);
        load_str();
        for (int b = 0; b < 40 && n_seen < 1; b++) @(negedge clk);
        check("reset_test_first_cw", n_seen, 32'd1);
        repeat (3) @(negedge clk);
        set_str("5$");
        begin_str(2);
        pin("pin_five_0", 0, mk(0, 0, 8'h35));
        pin("pin_five_1", 1, mk(0, 0, 8'h24));
        load_str();
        finish_str();

        // Randomized strings over small alphabets so matches are common.
        for (int t = 0; t < 25; t++) begin
            len   = $urandom_range(1, 30);
            alpha = $urandom_range(0, 4);
            str_q.delete();
            for (int i = 0; i < len; i++) str_q.push_back(8'h30 + 8'($urandom_range(0, alpha)));
            str_q.push_back(END_CHAR);
            begin_str($urandom_range(1, 3));
            load_str();
            finish_str();
        end

        // No terminator: the buffer fills and its last character ends it.
        str_q.delete();
        for (int i = 0; i < STR_LEN + 3; i++)
            str_q.push_back(($urandom_range(0, 15) == 0) ? 8'h31 : 8'h30);
        begin_str(2);
        load_str();
        finish_str();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lz77_encoder.md
Name: lz77_encoder

Overview:
- Streaming LZ77 encoder: the transmit side of the LZ77 codeword format consumed by LZ77_Decoder.
- Captures a hex-digit string terminated by '$' (8'h24), then emits one (code_pos, code_len, char_nxt) codeword per match.
- Uses a 9-entry search window and an 8-entry look-ahead window.
- Produces the golden codeword streams for decoder tests and is also a standalone block.

Parameters:
- STR_LEN, 2049: maximum characters stored, including the terminator.
- SEARCH_SIZE, 9: search-buffer depth; legal code_pos range is 0..SEARCH_SIZE-1.
- LA_SIZE, 8: look-ahead depth; maximum code_len is LA_SIZE-1.
- POS_W, 4: code_pos width.
- LEN_W, 3: code_len width.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- chardata  in  8  input character, one per cycle during LOAD.
- encode  out  1  high while encoding is in progress (LOAD through EMIT).
- valid  out  1  one-cycle strobe; the codeword outputs are meaningful in that cycle.
- code_pos  out  POS_W  match position; 0 means the most recent search-buffer character.
- code_len  out  LEN_W  match length.
- char_nxt  out  8  literal character that follows the match.
- finish  out  1  high after the last codeword; held until reset.

Behaviour:
- Reset: when reset==0 at a posedge, all outputs go to 0, the state goes to LOAD, and the write index and current position cur are cleared. This applies in any state, including mid-SEARCH or mid-EMIT; the partial string is discarded.
- LOAD:
  - encode=1.
  - Each cycle, chardata is written to str_buf[widx] and widx increments.
  - The first cycle after reset release is the first capture.
  - LOAD ends after capturing 8'h24, or after capturing STR_LEN characters; in the STR_LEN case the last stored character is treated as the terminator.
  - last_idx is the index of the terminator.
  - Next state: SEARCH with cur=0. Input after the terminator is ignored.
- SEARCH (exactly SEARCH_SIZE cycles, candidate p = 0..SEARCH_SIZE-1, one per cycle):
  - A candidate is legal only if cur-1-p >= 0.
  - Length for candidate p: the largest L <= min(LA_SIZE-1, last_idx-cur) such that str[cur-1-p+k] == str[cur+k] for all k < L. All k are compared in parallel.
  - Overlap into the look-ahead is allowed.
  - Best candidate: the greatest L; on a tie, the smaller p wins.
  - If the best L is 0, the codeword is (0, 0, str[cur]).
- EMIT (1 cycle):
  - valid=1 with code_pos=best_p, code_len=best_L, char_nxt=str[cur+best_L].
  - cur advances to cur+best_L+1.
  - If cur+best_L == last_idx, go to DONE; otherwise go back to SEARCH.
  - Codeword spacing is SEARCH_SIZE+1 = 10 cycles. The first valid appears 10 cycles after the last LOAD cycle.
- DONE:
  - encode=0 and finish=1 from the cycle after the final valid; held until reset.
- Output timing: valid is low outside EMIT. code_pos, code_len and char_nxt are registered and hold their last value between strobes.
- Invariants:
  - The terminator is never part of a match.
  - char_nxt of the final codeword is always the terminator.

Decomposition:
- Shared package lz77_pkg: SEARCH_SIZE, LA_SIZE, POS_W, LEN_W, END_CHAR = 8'h24, and a state enum {LOAD, SEARCH, EMIT, DONE}. The decoder shares this package.
- One sub-module, lz77_match_len (combinational):
  - Inputs: search-window slice, look-ahead slice, length cap.
  - Output: match length.
  - The length is the count of leading equal characters, clipped to the cap.

Test Plan:
- "$" → one codeword (0,0,8'h24); finish=1 on the next cycle; encode falls at the same time.
- "1111$" → (0,0,'1') then (0,3,'$'). The second codeword checks overlap matching and the cap at last_idx; exactly 2 valid strobes.
- "ABAB$" → (0,0,'A'), (0,0,'B'), (1,2,'$').
- "000000000$" (9 zeros) → (0,0,'0'), (0,7,'0'), (0,0,'$'). Checks the LA_SIZE-1 length cap and the smallest-p tie-break.
- Timing: 17-character string → valid strobes exactly 10 cycles apart. The first valid arrives 10 cycles after the terminator is captured; encode stays 1 throughout.
- Reset mid-SEARCH of the 2nd codeword of "0123$", drive reset=0 for 2 cycles → all outputs 0 the following cycle. Then reload with "5$" → (0,0,'5'), (0,0,'$'), then finish.
